coin_eject_sequencer: RTL and testbench

//  Downstream of the change calculator. Takes the combinational quarter/dime/nickel counts
//  as a one-cycle load. Drives the three hopper eject solenoids one coin at a time.

---
 rtl/coin_eject_sequencer_pkg.sv | 29 ++
 rtl/coin_eject_sequencer_cycle_timer.sv | 26 ++
 rtl/coin_eject_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_coin_eject_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_eject_sequencer_pkg.sv
// Shared types and coin values for the change-dispense path.
package coin_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_DROP,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {Q, D, N} denom_t;

    localparam int QUARTER = 25;
    localparam int DIME    = 10;
    localparam int NICKEL  = 5;

    // Fixed dispense order: quarters first, then dimes, then nickels.
    function automatic denom_t first_denom(input logic q_nz, input logic d_nz);
        if (q_nz)
            return Q;
        else if (d_nz)
            return D;
        else
            return N;
    endfunction

endpackage

// File: rtl/coin_eject_sequencer_cycle_timer.sv
// Loadable down-counter that stops at zero and flags it.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= value;
        else if (en && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/coin_eject_sequencer.sv
// Hopper eject sequencer: pulses one solenoid per coin, confirms each drop, reports done or jam.
//
//   state       | meaning
//   S_IDLE      | waiting for start
//   S_PULSE     | active solenoid driven for PULSE_CYCLES
//   S_WAIT_DROP | pulse finished, waiting for the drop sensor
//   S_GAP       | settle time after a confirmed drop
//   S_DONE      | all coins confirmed; done pulses on the following cycle
//   S_FAULT     | drop not seen in time; holds until the next start
module coin_eject_sequencer
    import coin_pkg::*;
#(
    parameter int CNT_W        = 5,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int ACK_TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] quarters_in,
    input  logic [CNT_W-1:0] dimes_in,
    input  logic [CNT_W-1:0] nickels_in,
    input  logic             coin_sensed,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] rem_q,
    output logic [CNT_W-1:0] rem_d,
    output logic [CNT_W-1:0] rem_n
);

    localparam int PG_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PG_W   = $clog2(PG_MAX + 1);
    localparam int AT_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [PG_W-1:0] PULSE_LD = PG_W'(PULSE_CYCLES - 1);
    localparam logic [PG_W-1:0] GAP_LD   = PG_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AT_W-1:0] ACK_LD   = AT_W'(ACK_TIMEOUT - 1);

    state_t           state, state_nxt, after_drop;
    denom_t           act, act_nxt;
    logic             got, got_nxt;
    logic [CNT_W-1:0] rq_nxt, rd_nxt, rn_nxt;
    logic             accept, drop_ok, any_nxt;
    logic             enter_pulse, enter_gap;
    logic             pg_load, pg_en, pg_zero;
    logic [PG_W-1:0]  pg_val;
    logic             at_load, at_en, at_zero;
    logic             ej_q_nxt, ej_d_nxt, ej_n_nxt;
    logic             busy_nxt, done_nxt, fault_nxt;

    assign pg_en = (state == S_PULSE) || (state == S_GAP);
    assign at_en = (state == S_PULSE) || (state == S_WAIT_DROP);

    cycle_timer #(.W(PG_W)) u_pg_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pg_load),
        .value (pg_val),
        .en    (pg_en),
        .zero  (pg_zero)
    );

    cycle_timer #(.W(AT_W)) u_ack_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (at_load),
        .value (ACK_LD),
        .en    (at_en),
        .zero  (at_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            act     <= Q;
            got     <= 1'b0;
            rem_q   <= '0;
            rem_d   <= '0;
            rem_n   <= '0;
            eject_q <= 1'b0;
            eject_d <= 1'b0;
            eject_n <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            act     <= act_nxt;
            got     <= got_nxt;
            rem_q   <= rq_nxt;
            rem_d   <= rd_nxt;
            rem_n   <= rn_nxt;
            eject_q <= ej_q_nxt;
            eject_d <= ej_d_nxt;
            eject_n <= ej_n_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            fault   <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        act_nxt     = act;
        got_nxt     = got;
        rq_nxt      = rem_q;
        rd_nxt      = rem_d;
        rn_nxt      = rem_n;
        accept      = 1'b0;
        drop_ok     = 1'b0;
        after_drop  = S_GAP;
        enter_pulse = 1'b0;
        enter_gap   = 1'b0;
        pg_load     = 1'b0;
        pg_val      = PULSE_LD;
        at_load     = 1'b0;

        case (state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    accept = 1'b1;
                    rq_nxt = quarters_in;
                    rd_nxt = dimes_in;
                    rn_nxt = nickels_in;
                end
            end
            S_PULSE:     drop_ok = coin_sensed && !got;
            S_WAIT_DROP: drop_ok = coin_sensed;
            default:     ;
        endcase

        // One confirmed drop per pulse; the guards keep the counts from wrapping.
        if (drop_ok) begin
            case (act)
                Q:       if (rem_q != '0) rq_nxt = rem_q - 1'b1;
                D:       if (rem_d != '0) rd_nxt = rem_d - 1'b1;
                N:       if (rem_n != '0) rn_nxt = rem_n - 1'b1;
                default: ;
            endcase
        end

        any_nxt = (rq_nxt != '0) || (rd_nxt != '0) || (rn_nxt != '0);
        if (GAP_CYCLES == 0)
            after_drop = any_nxt ? S_PULSE : S_DONE;

        case (state)
            S_IDLE, S_FAULT: begin
                if (accept)
                    state_nxt = any_nxt ? S_PULSE : S_DONE;
            end
            S_PULSE: begin
                if (at_zero && !got && !drop_ok)
                    state_nxt = S_FAULT;
                else if (pg_zero)
                    state_nxt = (got || drop_ok) ? after_drop : S_WAIT_DROP;
                else
                    got_nxt = got || drop_ok;
            end
            S_WAIT_DROP: begin
                if (drop_ok)
                    state_nxt = after_drop;
                else if (at_zero)
                    state_nxt = S_FAULT;
            end
            S_GAP: begin
                if (pg_zero)
                    state_nxt = any_nxt ? S_PULSE : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        enter_pulse = (state_nxt == S_PULSE) && ((state != S_PULSE) || pg_zero);
        enter_gap   = (state_nxt == S_GAP) && (state != S_GAP);
        pg_load     = enter_pulse || enter_gap;
        pg_val      = enter_gap ? GAP_LD : PULSE_LD;
        at_load     = enter_pulse;
        if (enter_pulse) begin
            act_nxt = first_denom(rq_nxt != '0, rd_nxt != '0);
            got_nxt = 1'b0;
        end
    end

    // Flop inputs for the outputs; the denomination is latched at pulse entry so a
    // mid-pulse drop cannot switch solenoids.
    always_comb begin
        ej_q_nxt  = (state_nxt == S_PULSE) && (act_nxt == Q);
        ej_d_nxt  = (state_nxt == S_PULSE) && (act_nxt == D);
        ej_n_nxt  = (state_nxt == S_PULSE) && (act_nxt == N);
        busy_nxt  = (state_nxt == S_PULSE) || (state_nxt == S_WAIT_DROP) ||
                    (state_nxt == S_GAP) || (state_nxt == S_DONE);
        done_nxt  = (state == S_DONE);
        fault_nxt = (state_nxt == S_FAULT);
    end

endmodule

// File: tb/tb_coin_eject_sequencer.sv
// Scoreboard bench for coin_eject_sequencer: expected eject order queued at load, checked at each pulse.
module tb_coin_eject_sequencer;

    localparam int CNT_W = 5;
    localparam int PULSE = 4;
    localparam int GAP   = 8;
    localparam int ACK   = 1000;

    logic             clk, rst_n, start, coin_sensed;
    logic [CNT_W-1:0] quarters_in, dimes_in, nickels_in;
    logic             eject_q, eject_d, eject_n, busy, done, fault;
    logic [CNT_W-1:0] rem_q, rem_d, rem_n;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    int         cyc = 0;
    int         last_rise_cyc = 0;
    int         resp_delay = 3;
    int         skip_no = 0;
    int         pulse_no = 0;
    int         spur_cnt = 0;
    bit         spur_gap = 0;
    bit         rst_test = 0;
    bit         got_done, got_fault, ok;

    coin_eject_sequencer #(
        .CNT_W(CNT_W), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .quarters_in(quarters_in), .dimes_in(dimes_in), .nickels_in(nickels_in),
        .coin_sensed(coin_sensed),
        .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
        .busy(busy), .done(done), .fault(fault),
        .rem_q(rem_q), .rem_d(rem_d), .rem_n(rem_n)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor: order from the scoreboard, width and one-hot from constants.
    initial begin : mon
        logic [2:0] ej, prev;
        int width;
        prev = 0;
        width = 0;
        forever begin
            @(negedge clk);
            ej = {eject_q, eject_d, eject_n};
            if (ej != 0) begin
                chk("eject_onehot", $countones(ej), 1);
                if (prev == 0) begin
                    width = 0;
                    last_rise_cyc = cyc;
                    if (exp_q.size() == 0) chk("eject_unexpected", ej, 0);
                    else chk("eject_order", ej, exp_q.pop_front());
                end
                width++;
            end else if (prev != 0 && !rst_test) begin
                chk("pulse_width", width, PULSE);
            end
            prev = ej;
        end
    end

    // Drop sensor model: answers each pulse after resp_delay cycles unless skipped.
    initial begin : resp
        logic prev;
        int spur_done;
        prev = 0;
        spur_done = 0;
        coin_sensed = 0;
        forever begin
            @(negedge clk);
            if (spur_cnt != spur_done) begin
                spur_done++;
                coin_sensed = 1;
                @(negedge clk);
                coin_sensed = 0;
            end else if ((eject_q | eject_d | eject_n) && !prev) begin
                pulse_no++;
                if (pulse_no != skip_no) begin
                    repeat (resp_delay) @(negedge clk);
                    coin_sensed = 1;
                    @(negedge clk);
                    coin_sensed = 0;
                    if (spur_gap) begin
                        repeat (2) @(negedge clk);
                        coin_sensed = 1;
                        @(negedge clk);
                        coin_sensed = 0;
                    end
                end
            end
            prev = eject_q | eject_d | eject_n;
        end
    end

    task automatic load(input int q, input int d, input int n);
        @(negedge clk);
        quarters_in = CNT_W'(q);
        dimes_in    = CNT_W'(d);
        nickels_in  = CNT_W'(n);
        start       = 1;
        for (int i = 0; i < q; i++) exp_q.push_back(3'b100);
        for (int i = 0; i < d; i++) exp_q.push_back(3'b010);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b001);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("fault_cleared", fault, 0);
    endtask

    task automatic wait_end(input int budget, output bit dn, output bit ft);
        dn = 0;
        ft = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin dn = 1; break; end
            if (fault === 1'b1) begin ft = 1; break; end
        end
        if (!dn && !ft) chk("end_timeout", 0, 1);
    endtask

    task automatic wait_ej(input logic [2:0] which, output bit found);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({eject_q, eject_d, eject_n} == which) begin found = 1; break; end
        end
        if (!found) chk("wait_eject_timeout", 0, 1);
    endtask

    task automatic after_done(input string tag);
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_rem_zero"}, {rem_q, rem_d, rem_n}, 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 0; start = 0;
        quarters_in = 0; dimes_in = 0; nickels_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_ejects", {eject_q, eject_d, eject_n}, 0);
        chk("rst_flags", {busy, done, fault}, 0);
        chk("rst_rem", {rem_q, rem_d, rem_n}, 0);
        rst_n = 1;
        @(negedge clk);

        // 65c: q,q,d,n
        load(2, 1, 1);
        wait_end(500, got_done, got_fault);
        after_done("t1");

        // all-zero load
        load(0, 0, 0);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        @(negedge clk);
        chk("t2_done_1cyc", done, 0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // jam on the second quarter
        skip_no = pulse_no + 2;
        load(3, 0, 0);
        void'(exp_q.pop_back());
        wait_end(3000, got_done, got_fault);
        chk("t3_fault_seen", got_fault, 1);
        chk("t3_fault_time", cyc - last_rise_cyc, ACK);
        chk("t3_rem_q", rem_q, 2);
        chk("t3_busy", busy, 0);
        chk("t3_ejects", {eject_q, eject_d, eject_n}, 0);
        chk("t3_sb_empty", exp_q.size(), 0);
        spur_cnt++;
        repeat (4) @(negedge clk);
        chk("t3_spur_rem_q", rem_q, 2);
        chk("t3_fault_sticky", fault, 1);
        skip_no = 0;
        load(1, 0, 0);
        wait_end(500, got_done, got_fault);
        after_done("t3b");

        // start while busy is ignored
        load(1, 1, 0);
        wait_ej(3'b100, ok);
        quarters_in = 7; dimes_in = 3; nickels_in = 2;
        start = 1;
        repeat (2) @(negedge clk);
        chk("t4_rem_q_hold", rem_q, 1);
        chk("t4_rem_d_hold", rem_d, 1);
        wait_ej(3'b010, ok);
        chk("t4_rem_d_dime", rem_d, 1);
        start = 0;
        wait_end(500, got_done, got_fault);
        after_done("t4");

        // reset during a dime pulse
        load(0, 2, 0);
        wait_ej(3'b010, ok);
        #3;
        rst_test = 1;
        rst_n = 0;
        #1;
        chk("t5_eject_d_async", eject_d, 0);
        chk("t5_flags", {busy, done, fault}, 0);
        chk("t5_rem", {rem_q, rem_d, rem_n}, 0);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        repeat (6) @(negedge clk);
        rst_test = 0;
        load(0, 1, 1);
        wait_end(500, got_done, got_fault);
        after_done("t5");

        // spurious sensor in GAP, then IDLE, then an early drop inside PULSE
        spur_gap = 1;
        load(2, 0, 0);
        wait_end(500, got_done, got_fault);
        after_done("t6_gap");
        spur_gap = 0;
        spur_cnt++;
        repeat (4) @(negedge clk);
        chk("t6_idle_rem", {rem_q, rem_d, rem_n}, 0);
        chk("t6_idle_busy", busy, 0);
        resp_delay = 0;
        load(1, 1, 0);
        wait_end(500, got_done, got_fault);
        after_done("t6_early");
        resp_delay = 3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
